// File: rtl/booth_mult_if.sv
// Start/done request bundle between an issuing datapath and the sequential Booth multiplier.
// Handshake: start is accepted only on an edge where busy=0; done pulses for one cycle with product valid.
interface booth_mult_if #(
    parameter int N = 32
) ();
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Iterative Booth multiplier: one radix-2 or radix-4 recoding step per clock,
// signed or unsigned operands per operation, one operation in flight.
module booth_mult_seq #(
    parameter int N      = 32,
    parameter bit RADIX4 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    booth_mult_if.slave bus,
    output logic [1:0]  state_dbg
);
    localparam int W    = RADIX4 ? N + 2 : N + 1;
    localparam int AW   = W + 1;
    localparam int ITER = RADIX4 ? (N + 2) / 2 : N + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PH   = 2 * N - W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [W-1:0]    m_q, m_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  product_q, product_d;

    logic [AW-1:0]   m_ext, m_dbl, addend, sum;
    logic [AW-1:0]   a_sh;
    logic [W-1:0]    q_sh;
    logic            qm1_sh;
    logic            accept, last_step;

    // Widen an operand to W bits so the top recoding step sees the true sign.
    function automatic logic [W-1:0] ext_op(input logic [N-1:0] x, input logic sgn);
        ext_op = {{(W-N){sgn & x[N-1]}}, x};
    endfunction

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_step = (state_q == S_RUN) && (count_q == CW'(1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One recoding step: select the partial product, accumulate, then shift {A,Q,q_-1}.
    always_comb begin
        m_ext  = {m_q[W-1], m_q};
        m_dbl  = {m_q, 1'b0};
        addend = '0;
        if (RADIX4) begin
            case ({q_q[1:0], qm1_q})
                3'b001, 3'b010: addend = m_ext;
                3'b011:         addend = m_dbl;
                3'b100:         addend = ~m_dbl + AW'(1);
                3'b101, 3'b110: addend = ~m_ext + AW'(1);
                default:        addend = '0;
            endcase
        end else begin
            case ({q_q[0], qm1_q})
                2'b01:   addend = m_ext;
                2'b10:   addend = ~m_ext + AW'(1);
                default: addend = '0;
            endcase
        end
        sum = a_q + addend;
        if (RADIX4) begin
            a_sh   = {{2{sum[AW-1]}}, sum[AW-1:2]};
            q_sh   = {sum[1:0], q_q[W-1:2]};
            qm1_sh = q_q[1];
        end else begin
            a_sh   = {sum[AW-1], sum[AW-1:1]};
            q_sh   = {sum[0], q_q[W-1:1]};
            qm1_sh = q_q[0];
        end
    end

    // Datapath register updates
    always_comb begin
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        if (accept) begin
            a_d     = '0;
            q_d     = ext_op(bus.multiplier, bus.signed_mode);
            qm1_d   = 1'b0;
            m_d     = ext_op(bus.multiplicand, bus.signed_mode);
            count_d = CW'(ITER);
        end else if (state_q == S_RUN) begin
            a_d     = a_sh;
            q_d     = q_sh;
            qm1_d   = qm1_sh;
            count_d = count_q - CW'(1);
            // The low 2N bits of the final {A,Q} are exact for both signed and unsigned.
            if (last_step) product_d = {a_sh[PH-1:0], q_sh};
        end
    end

    // Outputs
    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.product = product_q;
        state_dbg   = state_q;
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed checks of booth_mult_seq: N=32 radix-4, N=32 radix-2 and N=8 radix-4 instances.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  logic [31:0] op_a, op_b;
  logic        op_s;
  logic        go4, go2, go8;
  logic [1:0]  st4, st2, st8;

  booth_mult_if #(.N(32)) bus4 ();
  booth_mult_if #(.N(32)) bus2 ();
  booth_mult_if #(.N(8))  bus8 ();

  assign bus4.start = go4;
  assign bus4.signed_mode = op_s;
  assign bus4.multiplicand = op_a;
  assign bus4.multiplier = op_b;
  assign bus2.start = go2;
  assign bus2.signed_mode = op_s;
  assign bus2.multiplicand = op_a;
  assign bus2.multiplier = op_b;
  assign bus8.start = go8;
  assign bus8.signed_mode = op_s;
  assign bus8.multiplicand = op_a[7:0];
  assign bus8.multiplier = op_b[7:0];

  booth_mult_seq #(.N(32), .RADIX4(1'b1)) u_r4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .state_dbg(st4));
  booth_mult_seq #(.N(32), .RADIX4(1'b0)) u_r2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(st2));
  booth_mult_seq #(.N(8),  .RADIX4(1'b1)) u_n8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .state_dbg(st8));

  // ---------------- access helpers (w: 0=N32 R4, 1=N32 R2, 2=N8 R4)
  task automatic set_go(input int w, input logic v);
    case (w)
      0: go4 = v;
      1: go2 = v;
      default: go8 = v;
    endcase
  endtask

  function automatic logic dut_done(input int w);
    case (w)
      0: return bus4.done;
      1: return bus2.done;
      default: return bus8.done;
    endcase
  endfunction

  function automatic logic dut_busy(input int w);
    case (w)
      0: return bus4.busy;
      1: return bus2.busy;
      default: return bus8.busy;
    endcase
  endfunction

  function automatic logic [63:0] dut_prod(input int w);
    case (w)
      0: return bus4.product;
      1: return bus2.product;
      default: return {48'b0, bus8.product};
    endcase
  endfunction

  // ---------------- checkers
  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One operation. Cycle k=1 is the cycle right after the start edge; done must appear in
  // cycle exp_lat and busy must be high in every cycle up to and including it.
  task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag, input int exp_lat,
                        input bit disturb);
    int k;
    int nb;
    int extra;
    bit seen;
    @(negedge clk);
    op_s = s; op_a = a; op_b = b;
    set_go(w, 1'b1);
    @(posedge clk); #1;
    set_go(w, 1'b0);
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; op_s = ~s;
    k = 1; nb = int'(dut_busy(w)); seen = 1'b0;
    while (k < 200) begin
      if (dut_done(w)) begin
        seen = 1'b1;
        break;
      end
      if (disturb && k == 5) begin
        op_a = 32'd5; op_b = 32'd5;
        set_go(w, 1'b1);
      end
      if (disturb && k == 6) set_go(w, 1'b0);
      @(posedge clk); #1;
      k++;
      nb += int'(dut_busy(w));
    end
    chk_int({tag, "_done_seen"}, int'(seen), 1);
    chk_int({tag, "_latency"}, k, exp_lat);
    chk_int({tag, "_busy_cycles"}, nb, exp_lat);
    chk64({tag, "_product"}, dut_prod(w), exp);
    @(posedge clk); #1;
    chk_int({tag, "_idle_after"}, int'(dut_busy(w)), 0);
    chk64({tag, "_product_held"}, dut_prod(w), exp);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        extra += int'(dut_done(w));
      end
      chk_int({tag, "_no_extra_done"}, extra, 0);
    end
  endtask

  // ---------------- directed sequence
  initial begin
    int k;
    go4 = 1'b0; go2 = 1'b0; go8 = 1'b0;
    op_a = '0; op_b = '0; op_s = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk64("reset_product_r4", bus4.product, 64'h0);
    chk_int("reset_busy_r4", int'(bus4.busy), 0);
    chk_int("reset_done_r4", int'(bus4.done), 0);
    chk_int("reset_state_r4", int'(st4), 0);
    chk64("reset_product_r2", bus2.product, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // N=32 radix-4: done in cycle 18 after the start edge
    run_op(0, 1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, "r4_s_m7x3", 18, 1'b0);
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "r4_u_max", 18, 1'b0);
    run_op(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, "r4_s_m1xm1", 18, 1'b0);
    run_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "r4_s_minxmin", 18, 1'b0);
    run_op(0, 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "r4_s_minx1", 18, 1'b0);
    run_op(0, 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "r4_u_2pow32", 18, 1'b0);

    // N=32 radix-2: 34 cycles busy
    run_op(1, 1'b1, 32'd12, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFC4, "r2_s_12xm5", 34, 1'b0);
    run_op(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "r2_u_max", 34, 1'b0);
    run_op(1, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "r2_s_minxmin", 34, 1'b0);

    // N=8 radix-4: ITER=5
    run_op(2, 1'b1, 32'h80, 32'h80, 64'h4000, "n8_s_minxmin", 6, 1'b0);
    run_op(2, 1'b0, 32'hFF, 32'hFF, 64'hFE01, "n8_u_max", 6, 1'b0);
    run_op(2, 1'b1, 32'hFF, 32'h7F, 64'hFF81, "n8_s_m1x127", 6, 1'b0);

    // start pulsed mid-RUN with new operands is ignored
    run_op(0, 1'b1, 32'd123, 32'hFFFF_FE38, 64'hFFFF_FFFF_FFFF_24E8, "r4_mid_start", 18, 1'b1);

    // start held high: ignored in the done cycle, accepted in the first idle cycle after
    @(negedge clk);
    op_s = 1'b1; op_a = 32'hFFFF_FFF9; op_b = 32'd3;
    go4 = 1'b1;
    @(posedge clk); #1;
    k = 1;
    while (k < 200 && !bus4.done) begin
      @(posedge clk); #1;
      k++;
    end
    chk_int("b2b_first_latency", k, 18);
    chk64("b2b_first_product", bus4.product, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk); #1;
    chk_int("b2b_idle_after_done", int'(bus4.busy), 0);
    @(posedge clk); #1;
    chk_int("b2b_accepted_in_idle", int'(bus4.busy), 1);
    go4 = 1'b0;
    k = 1;
    while (k < 200 && !bus4.done) begin
      @(posedge clk); #1;
      k++;
    end
    chk_int("b2b_second_latency", k, 18);
    chk64("b2b_second_product", bus4.product, 64'hFFFF_FFFF_FFFF_FFEB);

    // asynchronous reset mid-RUN aborts the operation
    @(negedge clk);
    op_s = 1'b0; op_a = 32'd1000; op_b = 32'd1000;
    go4 = 1'b1;
    @(posedge clk); #1;
    go4 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("rst_mid_busy", int'(bus4.busy), 0);
    chk_int("rst_mid_done", int'(bus4.done), 0);
    chk64("rst_mid_product", bus4.product, 64'h0);
    chk_int("rst_mid_state", int'(st4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 32'd1000, 32'd1000, 64'd1000000, "r4_after_reset", 18, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
